// File: rtl/seg7_scan_to_bcd.sv
// rtl/seg7_scan_to_bcd.sv - debounced capture of a multiplexed 7-segment display scan into a 4-digit BCD frame
module seg7_scan_to_bcd #(
    parameter int STABLE_CNT = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_seg,
    input  logic [3:0]  i_dig_sel,
    input  logic        i_strobe,
    output logic [15:0] o_BCD,
    output logic [3:0]  o_blank,
    output logic [3:0]  o_dp,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_timeout
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_EMIT    = 2'd2;

    localparam int          TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0]  STABLE   = 4'(STABLE_CNT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    mask_q, mask_d, mask_base;
    logic [11:0]   pat_q, pat_d;
    logic [3:0]    stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   slot_bcd_q, slot_bcd_d;
    logic [3:0]    slot_blank_q, slot_blank_d;
    logic [3:0]    slot_dp_q, slot_dp_d;
    logic [3:0]    slot_err_q, slot_err_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    dp_q, dp_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;

    logic          qual, same, accept;
    logic [5:0]    dec;

    // Returns {blank, err, nibble}
    function automatic logic [5:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = {2'b00, 4'h0};
            7'h06:   decode = {2'b00, 4'h1};
            7'h5B:   decode = {2'b00, 4'h2};
            7'h4F:   decode = {2'b00, 4'h3};
            7'h66:   decode = {2'b00, 4'h4};
            7'h6D:   decode = {2'b00, 4'h5};
            7'h7D:   decode = {2'b00, 4'h6};
            7'h07:   decode = {2'b00, 4'h7};
            7'h7F:   decode = {2'b00, 4'h8};
            7'h6F:   decode = {2'b00, 4'h9};
            7'h00:   decode = {2'b10, 4'hF};
            default: decode = {2'b01, 4'hE};
        endcase
    endfunction

    assign qual = i_strobe && (i_dig_sel != 4'd0) && ((i_dig_sel & (i_dig_sel - 4'd1)) == 4'd0);
    assign same = ({i_dig_sel, i_seg} == pat_q);
    assign dec  = decode(i_seg[6:0]);

    // A saturated counter sitting at STABLE must not re-accept the same pattern
    always_comb begin
        stab_d = stab_q;
        pat_d  = pat_q;
        accept = 1'b0;
        if (qual) begin
            pat_d  = {i_dig_sel, i_seg};
            stab_d = same ? ((stab_q == 4'hF) ? 4'hF : stab_q + 4'd1) : 4'd1;
            accept = (stab_d == STABLE) && !(same && (stab_q == STABLE));
        end else if (i_strobe) begin
            stab_d = 4'd0;
        end
    end

    always_comb begin
        slot_bcd_d   = slot_bcd_q;
        slot_blank_d = slot_blank_q;
        slot_dp_d    = slot_dp_q;
        slot_err_d   = slot_err_q;
        for (int i = 0; i < 4; i++) begin
            if (accept && i_dig_sel[i]) begin
                slot_bcd_d[i*4 +: 4] = dec[3:0];
                slot_blank_d[i]      = dec[5];
                slot_err_d[i]        = dec[4];
                slot_dp_d[i]         = i_seg[7];
            end
        end
    end

    assign mask_base = (state_q == S_EMIT) ? 4'd0 : mask_q;

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_base;
        tmo_d     = '0;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        dp_d      = dp_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE, S_EMIT: begin
                if (accept) begin
                    mask_d  = mask_base | i_dig_sel;
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    mask_d = mask_q | i_dig_sel;
                    if (mask_d == 4'hF) begin
                        state_d = S_EMIT;
                        valid_d = 1'b1;
                        bcd_d   = slot_bcd_d;
                        blank_d = slot_blank_d;
                        dp_d    = slot_dp_d;
                        err_d   = |slot_err_d;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    mask_d    = 4'd0;
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                mask_d  = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            mask_q       <= 4'd0;
            pat_q        <= 12'd0;
            stab_q       <= 4'd0;
            tmo_q        <= '0;
            slot_bcd_q   <= 16'd0;
            slot_blank_q <= 4'd0;
            slot_dp_q    <= 4'd0;
            slot_err_q   <= 4'd0;
            bcd_q        <= 16'd0;
            blank_q      <= 4'd0;
            dp_q         <= 4'd0;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            pat_q        <= pat_d;
            stab_q       <= stab_d;
            tmo_q        <= tmo_d;
            slot_bcd_q   <= slot_bcd_d;
            slot_blank_q <= slot_blank_d;
            slot_dp_q    <= slot_dp_d;
            slot_err_q   <= slot_err_d;
            bcd_q        <= bcd_d;
            blank_q      <= blank_d;
            dp_q         <= dp_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_BCD       = bcd_q;
    assign o_blank     = blank_q;
    assign o_dp        = dp_q;
    assign o_frame_err = err_q;
    assign o_valid     = valid_q;
    assign o_timeout   = timeout_q;
endmodule

// File: tb/tb_seg7_scan_to_bcd.sv
// tb/tb_seg7_scan_to_bcd.sv - self-checking bench for seg7_scan_to_bcd
module tb_seg7_scan_to_bcd;
    localparam int STABLE_CNT = 2;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  sel;
    logic        strobe;
    logic [15:0] o_bcd;
    logic [3:0]  o_blank, o_dp;
    logic        o_valid, o_frame_err, o_timeout;

    int checks = 0;
    int errors = 0;

    seg7_scan_to_bcd #(.STABLE_CNT(STABLE_CNT), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_dig_sel(sel), .i_strobe(strobe),
        .o_BCD(o_bcd), .o_blank(o_blank), .o_dp(o_dp), .o_valid(o_valid),
        .o_frame_err(o_frame_err), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int digit_seg[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Reference model state: frame contents per digit position 0..3
    int m_prev, m_cnt, m_mask, m_tmo;
    bit m_emit;
    int m_nib[4];
    bit m_blank[4], m_dp[4], m_err[4];
    logic [15:0] e_bcd;
    logic [3:0]  e_blank, e_dp;
    logic        e_err, e_valid, e_tmo;
    int seen_valid, seen_tmo;

    task automatic model_edge(input bit r, input bit stb, input logic [3:0] s, input logic [7:0] g);
        bit acc, same;
        int old, pat, idx, code;
        e_valid = 0;
        e_tmo   = 0;
        if (r) begin
            m_prev = -1; m_cnt = 0; m_mask = 0; m_tmo = 0; m_emit = 0;
            e_bcd = 0; e_blank = 0; e_dp = 0; e_err = 0;
        end else begin
            acc = 0;
            if (stb) begin
                if ($countones(s) == 1) begin
                    pat  = {s, g};
                    same = (pat == m_prev);
                    old  = m_cnt;
                    m_cnt = same ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 1;
                    acc = (m_cnt == STABLE_CNT) && !(same && old == STABLE_CNT);
                    m_prev = pat;
                end else begin
                    m_cnt = 0;
                end
            end
            if (m_emit) m_mask = 0;
            m_emit = 0;
            if (acc) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (s[i]) idx = i;
                code = g[6:0];
                m_blank[idx] = (code == 0);
                m_err[idx]   = 0;
                m_dp[idx]    = g[7];
                if (code == 0) m_nib[idx] = 15;
                else begin
                    m_nib[idx] = 14;
                    m_err[idx] = 1;
                    for (int d = 0; d < 10; d++) if (digit_seg[d] == code) begin
                        m_nib[idx] = d;
                        m_err[idx] = 0;
                    end
                end
                m_mask = m_mask | s;
                m_tmo  = 0;
                if (m_mask == 15) begin
                    e_bcd = {m_nib[3][3:0], m_nib[2][3:0], m_nib[1][3:0], m_nib[0][3:0]};
                    e_blank = {m_blank[3], m_blank[2], m_blank[1], m_blank[0]};
                    e_dp    = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
                    e_err   = m_err[0] | m_err[1] | m_err[2] | m_err[3];
                    e_valid = 1;
                    m_emit  = 1;
                end
            end else if (m_mask != 0) begin
                m_tmo++;
                if (m_tmo == TIMEOUT) begin
                    m_mask = 0;
                    m_tmo  = 0;
                    e_tmo  = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert ({o_valid, o_timeout} === {e_valid, e_tmo}) else begin
            errors++;
            $error("FAIL pulses observed valid/timeout=%b%b expected=%b%b", o_valid, o_timeout, e_valid, e_tmo);
        end
        checks++;
        assert ({o_bcd, o_blank, o_dp, o_frame_err} === {e_bcd, e_blank, e_dp, e_err}) else begin
            errors++;
            $error("FAIL frame observed bcd=%h blank=%b dp=%b err=%b expected bcd=%h blank=%b dp=%b err=%b",
                   o_bcd, o_blank, o_dp, o_frame_err, e_bcd, e_blank, e_dp, e_err);
        end
        if (o_valid) seen_valid++;
        if (o_timeout) seen_tmo++;
    endtask

    task automatic step(input bit r, input bit stb, input logic [3:0] s, input logic [7:0] g);
        rst = r; strobe = stb; sel = s; seg = g;
        @(posedge clk);
        model_edge(r, stb, s, g);
        #1;
        check_outputs();
    endtask

    task automatic digit(input logic [3:0] s, input logic [7:0] g, input int n);
        for (int i = 0; i < n; i++) step(0, 1, s, g);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 4'd0, 8'd0);
    endtask

    initial begin
        rst = 1; strobe = 0; sel = 0; seg = 0;
        step(1, 0, 0, 0);
        step(1, 1, 4'd8, 8'h3F);
        checks++;
        assert ({o_bcd, o_blank, o_dp, o_valid, o_frame_err, o_timeout} === 30'd0) else begin
            errors++;
            $error("FAIL reset observed=%h expected=0", {o_bcd, o_blank, o_dp, o_valid, o_frame_err, o_timeout});
        end

        // Basic frame 0123
        seen_valid = 0;
        digit(4'd8, 8'h3F, 2); digit(4'd4, 8'h06, 2); digit(4'd2, 8'h5B, 2); digit(4'd1, 8'h4F, 2);
        idle(2);
        checks++;
        assert ({seen_valid, o_bcd, o_blank, o_frame_err} === {32'd1, 16'h0123, 4'b0000, 1'b0}) else begin
            errors++;
            $error("FAIL frame_0123 observed=%0d/%h/%b/%b expected=1/0123/0000/0", seen_valid, o_bcd, o_blank, o_frame_err);
        end

        // Blank digit
        digit(4'd8, 8'h7F, 2); digit(4'd4, 8'h6F, 2); digit(4'd2, 8'h3F, 2); digit(4'd1, 8'h00, 2);
        idle(2);
        checks++;
        assert ({o_bcd, o_blank, o_frame_err} === {16'h890F, 4'b0001, 1'b0}) else begin
            errors++;
            $error("FAIL frame_blank observed=%h/%b/%b expected=890F/0001/0", o_bcd, o_blank, o_frame_err);
        end

        // Unrecognised pattern
        digit(4'd8, 8'h49, 2); digit(4'd4, 8'h3F, 2); digit(4'd2, 8'h3F, 2); digit(4'd1, 8'h3F, 2);
        idle(2);
        checks++;
        assert ({o_bcd, o_frame_err} === {16'hE000, 1'b1}) else begin
            errors++;
            $error("FAIL frame_err observed=%h/%b expected=E000/1", o_bcd, o_frame_err);
        end

        // Glitch on slot 0 must not be accepted
        digit(4'd1, 8'h3F, 1); digit(4'd1, 8'h06, 1); digit(4'd1, 8'h3F, 2);
        digit(4'd8, 8'h06, 2); digit(4'd4, 8'h5B, 2); digit(4'd2, 8'h4F, 2);
        idle(2);
        checks++;
        assert (o_bcd === 16'h1230) else begin
            errors++;
            $error("FAIL glitch observed=%h expected=1230", o_bcd);
        end

        // Timeout of a three-digit partial frame
        seen_valid = 0; seen_tmo = 0;
        digit(4'd8, 8'h06, 2); digit(4'd4, 8'h06, 2); digit(4'd2, 8'h06, 2);
        idle(TIMEOUT + 3);
        checks++;
        assert ({seen_valid, seen_tmo, o_bcd} === {32'd0, 32'd1, 16'h1230}) else begin
            errors++;
            $error("FAIL timeout observed valid=%0d tmo=%0d bcd=%h expected 0/1/1230", seen_valid, seen_tmo, o_bcd);
        end

        // Reset mid-frame, then a clean frame
        digit(4'd8, 8'h66, 2); digit(4'd4, 8'h6D, 2);
        step(1, 0, 0, 0);
        checks++;
        assert ({o_bcd, o_blank, o_dp, o_valid, o_frame_err, o_timeout} === 30'd0) else begin
            errors++;
            $error("FAIL midreset observed=%h expected=0", {o_bcd, o_blank, o_dp, o_valid, o_frame_err, o_timeout});
        end
        digit(4'd8, 8'hFD, 2); digit(4'd4, 8'h07, 2); digit(4'd2, 8'h66, 2); digit(4'd1, 8'h6D, 2);
        idle(2);
        checks++;
        assert ({o_bcd, o_dp} === {16'h6745, 4'b1000}) else begin
            errors++;
            $error("FAIL after_reset observed=%h/%b expected=6745/1000", o_bcd, o_dp);
        end

        // Non one-hot select clears the stability count
        digit(4'd8, 8'h06, 1); digit(4'd3, 8'h06, 1); digit(4'd8, 8'h06, 1);
        digit(4'd3, 8'h06, 1); digit(4'd8, 8'h06, 2);
        digit(4'd4, 8'h06, 2); digit(4'd2, 8'h06, 2); digit(4'd1, 8'h06, 2);
        idle(2);

        // Randomized scans
        for (int f = 0; f < 60; f++) begin
            int order[4];
            order = '{0, 1, 2, 3};
            order.shuffle();
            for (int k = 0; k < 4; k++) begin
                logic [7:0] g;
                logic [3:0] s;
                int pick;
                pick = $urandom_range(0, 12);
                g = (pick < 10) ? 8'(digit_seg[pick]) : (pick == 10) ? 8'h00 : 8'($urandom);
                g[7] = 1'($urandom);
                s = 4'd1 << order[k];
                for (int n = $urandom_range(1, 4); n > 0; n--) begin
                    if ($urandom_range(0, 9) == 0) step(0, 1, 4'($urandom), 8'($urandom));
                    else if ($urandom_range(0, 5) == 0) step(0, 0, 4'($urandom), 8'($urandom));
                    step(0, 1, s, g);
                end
            end
            if ($urandom_range(0, 4) == 0) idle($urandom_range(0, TIMEOUT + 4));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
